inst_buffer: RTL and testbench
==============================

// Module: inst_buffer
// PURPOSE
//  Circular FIFO between fetch and the reservation-station dispatch path.
//  Fetch pushes decoded instruction entries into the buffer.
//  The reservation-station block pops one entry per read_enable pulse.
//  Branch-mispredict flush (cdb take_branch) discards all buffered entries.
// PARAMETERS
//  DEPTH   8    number of entries; power of two, >= 2
//  DATA_W  128  entry width in bits (packed decoded-instruction payload)
// PORTS
//  clock        in   1                  system clock, all state on posedge
//  reset        in   1                  synchronous, active-high
//  flush        in   1                  discard all entries (cdb_packet.take_branch)
//  in_valid     in   1                  fetch offers an entry this cycle
//  in_data      in   DATA_W             entry payload from fetch
//  in_ready     out  1                  buffer accepts push this cycle (= !full)
//  read_enable  in   1                  pop request from reservation station
//  out_valid    out  1                  head entry present (= !empty)
//  out_data     out  DATA_W             head entry, show-ahead (combinational from storage)
//  count        out  $clog2(DEPTH)+1    current occupancy, 0..DEPTH
//  full         out  1                  count == DEPTH
//  empty        out  1                  count == 0
// BEHAVIOUR
//  - State: storage[DEPTH], head_ptr, tail_ptr ($clog2(DEPTH) bits), count.
//  - Reset values (synchronous):
//      head = tail = count = 0; empty = 1; full = 0; in_ready = 1; out_valid = 0.
//      out_data = 0 while empty.
//  - Push: in_valid && !full.
//      storage[tail] <= in_data; tail <= tail + 1, wrapping modulo DEPTH.
//  - Pop: read_enable && !empty.
//      head <= head + 1, wrapping modulo DEPTH.
//      Popped entry was visible on out_data in the same cycle (zero-latency read).
//  - Push latency: a pushed entry is visible on out_data the cycle after the push.
//      No same-cycle bypass from in_data to out_data.
//  - Simultaneous push and pop:
//      not full and not empty: both occur; count unchanged.
//      empty: push only; the pop is ignored; count becomes 1.
//      full: pop only; in_ready = 0 blocks the push; count becomes DEPTH-1.
//  - Flow control: in_ready depends only on registered state (count), never on read_enable.
//  - Ignored requests:
//      read_enable while empty: no state change, no underflow.
//      in_valid while full: data dropped; the producer must hold it until in_ready.
//  - Flush has priority over push and pop in the same cycle.
//      head = tail = count = 0 next cycle; the same-cycle push is discarded.
//      Storage contents need not be cleared; out_data = 0 while empty.
//  - Reset has priority over flush. Reset mid-stream behaves exactly like flush.
//  - count arithmetic: count_next = count + push_fire - pop_fire.
//      Never exceeds DEPTH; never goes below 0.
//  - Invariant: (tail - head) mod DEPTH == count mod DEPTH.
//      full and empty are derived from count, not from pointer equality.
// TESTING
//  1 Reset, then push 0xA1,0xA2,0xA3 on consecutive cycles, no pops
//    -> count=3; out_data=0xA1; empty=0.
//  2 Push DEPTH=8 entries, then one more with in_valid=1
//    -> full=1; in_ready=0; 9th entry dropped; pop order 1..8 intact.
//  3 At count=8, assert in_valid and read_enable together
//    -> pop only; count=7; head advances; pushed data not stored until next cycle.
//  4 At count=0, push 0x55 with read_enable=1
//    -> count=1 next cycle; out_data=0x55; no underflow.
//  5 At count=5, assert flush with in_valid=1 and read_enable=1
//    -> next cycle count=0; empty=1; out_valid=0; following push appears as new head.
//  6 Wrap-around: push/pop continuously for 20 cycles with data = cycle index
//    -> pops return data in order across pointer wrap; count stays 1 throughout steady state.

Source files
------------

// File: rtl/inst_buffer_if.sv
// Fetch-to-dispatch instruction buffer bus: push side, pop side, flush and status.
// master = fetch/reservation-station side, slave = the buffer itself.
interface inst_buffer_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 128
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              read_enable;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport master (
    output flush, in_valid, in_data, read_enable,
    input  in_ready, out_valid, out_data, count, full, empty
  );

  modport slave (
    input  flush, in_valid, in_data, read_enable,
    output in_ready, out_valid, out_data, count, full, empty
  );
endinterface

// File: rtl/inst_buffer.sv
// Circular instruction FIFO between fetch and reservation-station dispatch.
// Show-ahead head read, occupancy-derived full/empty, flush drops everything.
module inst_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 128
) (
  input  logic        clock,
  input  logic        reset,
  inst_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] storage [DEPTH];
  logic [PTR_W-1:0]  head_ptr;
  logic [PTR_W-1:0]  tail_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              full_w;
  logic              empty_w;
  logic              push_fire;
  logic              pop_fire;
  logic              clear;

  assign full_w    = (count_q == CNT_W'(DEPTH));
  assign empty_w   = (count_q == '0);
  assign push_fire = bus.in_valid && !full_w;
  assign pop_fire  = bus.read_enable && !empty_w;
  assign clear     = reset || bus.flush;

  always_ff @(posedge clock) begin
    if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else begin
      if (push_fire) tail_ptr <= tail_ptr + 1'b1;
      if (pop_fire)  head_ptr <= head_ptr + 1'b1;
      count_q <= count_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
    end
  end

  // Storage is never cleared; stale entries are masked by out_data gating below.
  always_ff @(posedge clock) begin
    if (push_fire && !clear) storage[tail_ptr] <= bus.in_data;
  end

  assign bus.in_ready  = !full_w;
  assign bus.out_valid = !empty_w;
  assign bus.out_data  = empty_w ? '0 : storage[head_ptr];
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer against a queue-based reference model.
module tb_inst_buffer;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 128;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int VEC_W  = CNT_W + 4 + DATA_W;

  logic clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  logic [DATA_W-1:0] q[$];

  inst_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus();

  inst_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Expected observable status, packed: {count, full, empty, in_ready, out_valid, out_data}
  function automatic logic [VEC_W-1:0] model_vec();
    logic [DATA_W-1:0] hd;
    int n;
    n  = q.size();
    hd = (n > 0) ? q[0] : '0;
    return {CNT_W'(n), n == DEPTH, n == 0, n != DEPTH, n != 0, hd};
  endfunction

  function automatic logic [VEC_W-1:0] dut_vec();
    return {bus.count, bus.full, bus.empty, bus.in_ready, bus.out_valid, bus.out_data};
  endfunction

  // One clock cycle of stimulus; the model follows the buffer's documented rules.
  task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic re,
                     input logic fl, input logic rs);
    bit push, pop;
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.read_enable = re;
    bus.flush       = fl;
    reset           = rs;
    push = v  && (q.size() < DEPTH);
    pop  = re && (q.size() > 0);
    @(posedge clock);
    if (rs || fl) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(d);
    end
    @(negedge clock);
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.read_enable = 1'b0;
    bus.flush       = 1'b0;
    reset           = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1'b1, rnd_data(), 1'b1, 1'b0, 1'b1);
    tests++;
    if (bus.count !== '0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    tests++;
    if ({bus.empty, bus.full, bus.in_ready, bus.out_valid} !== 4'b1010) begin
      fails++;
      $display("FAIL reset_flags: got e/f/r/v=%b%b%b%b want 1010", bus.empty, bus.full, bus.in_ready, bus.out_valid);
    end
    tests++;
    if (bus.out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
  endtask

  task automatic test_push_three();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, DATA_W'(8'hA1), 1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.out_data !== DATA_W'(8'hA1)) begin fails++; $display("FAIL push_latency: got %h want a1", bus.out_data); end
    cyc(1'b1, DATA_W'(8'hA2), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, DATA_W'(8'hA3), 1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.count !== CNT_W'(3)) begin fails++; $display("FAIL push3_count: got %0d want 3", bus.count); end
    tests++;
    if (bus.out_data !== DATA_W'(8'hA1) || bus.empty !== 1'b0) begin
      fails++; $display("FAIL push3_head: got %h empty=%b want a1 empty=0", bus.out_data, bus.empty);
    end
  endtask

  task automatic test_overflow();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, DATA_W'(i), 1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.full !== 1'b1 || bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL full_flags: got full=%b in_ready=%b want 1 0", bus.full, bus.in_ready);
    end
    cyc(1'b1, DATA_W'(9), 1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.count !== CNT_W'(DEPTH)) begin fails++; $display("FAIL overflow_count: got %0d want %0d", bus.count, DEPTH); end
    for (int i = 1; i <= DEPTH; i++) begin
      tests++;
      if (bus.out_data !== DATA_W'(i)) begin fails++; $display("FAIL drain_order[%0d]: got %h want %h", i, bus.out_data, DATA_W'(i)); end
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    tests++;
    if (bus.empty !== 1'b1 || bus.out_data !== '0) begin
      fails++; $display("FAIL drain_empty: got empty=%b data=%h want 1 0", bus.empty, bus.out_data);
    end
  endtask

  task automatic test_full_push_pop();
    logic [DATA_W-1:0] ent [DEPTH];
    logic [DATA_W-1:0] x;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      ent[i] = rnd_data();
      cyc(1'b1, ent[i], 1'b0, 1'b0, 1'b0);
    end
    x = rnd_data();
    cyc(1'b1, x, 1'b1, 1'b0, 1'b0);
    tests++;
    if (bus.count !== CNT_W'(DEPTH - 1)) begin fails++; $display("FAIL fullpp_count: got %0d want %0d", bus.count, DEPTH - 1); end
    tests++;
    if (bus.out_data !== ent[1]) begin fails++; $display("FAIL fullpp_head: got %h want %h", bus.out_data, ent[1]); end
    cyc(1'b1, x, 1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.count !== CNT_W'(DEPTH)) begin fails++; $display("FAIL fullpp_retry: got %0d want %0d", bus.count, DEPTH); end
    for (int i = 1; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tests++;
    if (bus.out_data !== x || bus.count !== CNT_W'(1)) begin
      fails++; $display("FAIL fullpp_tail: got %h cnt=%0d want %h cnt=1", bus.out_data, bus.count, x);
    end
  endtask

  task automatic test_empty_push_pop();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tests++;
    if (bus.count !== '0 || bus.empty !== 1'b1) begin
      fails++; $display("FAIL underflow: got cnt=%0d empty=%b want 0 1", bus.count, bus.empty);
    end
    cyc(1'b1, DATA_W'(8'h55), 1'b1, 1'b0, 1'b0);
    tests++;
    if (bus.count !== CNT_W'(1) || bus.out_data !== DATA_W'(8'h55)) begin
      fails++; $display("FAIL emptypp: got cnt=%0d data=%h want 1 55", bus.count, bus.out_data);
    end
  endtask

  task automatic test_flush();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, rnd_data(), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, DATA_W'(8'h77), 1'b1, 1'b1, 1'b0);
    tests++;
    if (bus.count !== '0 || bus.empty !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
      fails++;
      $display("FAIL flush_state: got cnt=%0d empty=%b valid=%b data=%h want 0 1 0 0",
               bus.count, bus.empty, bus.out_valid, bus.out_data);
    end
    cyc(1'b1, DATA_W'(8'h99), 1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.out_data !== DATA_W'(8'h99) || bus.count !== CNT_W'(1)) begin
      fails++; $display("FAIL flush_newhead: got %h cnt=%0d want 99 1", bus.out_data, bus.count);
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, rnd_data(), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, rnd_data(), 1'b1, 1'b0, 1'b1);
    tests++;
    if (bus.count !== '0 || bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL midstream_reset: got cnt=%0d valid=%b want 0 0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_wrap();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, DATA_W'(0), 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) begin
      tests++;
      if (bus.out_data !== DATA_W'(i - 1) || bus.count !== CNT_W'(1)) begin
        fails++;
        $display("FAIL wrap[%0d]: got data=%h cnt=%0d want %h 1", i, bus.out_data, bus.count, DATA_W'(i - 1));
      end
      cyc(1'b1, DATA_W'(i), 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [VEC_W-1:0] exp_v;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 99) < 60, rnd_data(), $urandom_range(0, 99) < 45,
          $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
      exp_v = model_vec();
      tests++;
      if (dut_vec() !== exp_v) begin
        fails++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), exp_v);
      end
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.read_enable = 1'b0;
    @(negedge clock);
    test_reset();
    test_push_three();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_flush();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
